aska_spi_cfg_master: RTL and testbench
======================================

Name: aska_spi_cfg_master

Overview:
- FPGA-side SPI Mode 0 master that configures aska_dig over its SPI_CS / SPI_Clk / SPI_MOSI slave port.
- Accepts configuration words from a host-side requester over a valid/ready handshake.
- Serializes each word MSB-first into one CS-framed transfer and enforces a minimum CS-high gap between frames.
- Sits between the board control logic and aska_dig in the FPGA test top, replacing manual pin drive of the gp[4:2] SPI lines.

Parameters:
- FRAME_W, 16: bits per SPI frame; legal range 2..32.
- CLK_DIV, 4: clk cycles per SPI half-period; must be ≥1.
- GAP_CYC, 8: minimum clk cycles CS stays high between frames; must be ≥1.
- FIFO_DEPTH, 4: command queue depth, power of 2; used only with ASKA_SPI_CFG_FIFO_EN.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset_l  in  1  synchronous, active-low reset.
- cmd_valid  in  1  requester has a word on cmd_data.
- cmd_ready  out  1  block can accept a word; transfer occurs when cmd_valid && cmd_ready at a rising edge.
- cmd_data  in  FRAME_W  word to send; bit FRAME_W-1 is sent first.
- SPI_CS  out  1  chip select, active low.
- SPI_Clk  out  1  SPI clock; idles low (Mode 0).
- SPI_MOSI  out  1  serial data to aska_dig.
- busy  out  1  frame in progress, including the post-frame gap.
- frame_done  out  1  one-cycle pulse when a frame completes.
- pending  out  1  at least one accepted word is waiting to start.

Behaviour:
- All outputs are registered.
- Reset (reset_l sampled low): SPI_CS=1, SPI_Clk=0, SPI_MOSI=0, busy=0, frame_done=0, pending=0, cmd_ready=0.
  - cmd_ready goes to 1 in the first cycle after reset_l is sampled high.
- Reset mid-frame: the frame aborts and SPI_CS rises at that edge. Queued words are discarded. No frame_done pulse.
- FSM states: IDLE, LOW, HIGH, HOLD, GAP.
  - IDLE -> LOW when a word is available.
    - Load the shift register, SPI_CS=0, SPI_MOSI=bit FRAME_W-1, busy=1, bit counter=0.
  - LOW: SPI_Clk=0 for CLK_DIV cycles, then -> HIGH.
  - HIGH: SPI_Clk=1 for CLK_DIV cycles. aska_dig samples MOSI on this rising edge. At the end of HIGH:
    - if bit counter = FRAME_W-1 -> HOLD;
    - else increment the counter, shift, drive the next bit on MOSI as SPI_Clk falls, and go -> LOW.
  - HOLD: SPI_Clk=0, SPI_CS=0 for CLK_DIV cycles, then -> GAP.
    - On entry to GAP: SPI_CS=1, SPI_MOSI=0, frame_done=1 for one cycle.
  - GAP: SPI_CS=1 for GAP_CYC cycles, then -> IDLE. busy drops to 0 on entry to IDLE.
- Frame timing: CS-low duration is exactly (2*FRAME_W+1)*CLK_DIV clk cycles (132 at defaults).
- MOSI changes only while SPI_Clk is low. MOSI is stable for CLK_DIV cycles before every SPI_Clk rising edge.
- A word waiting in IDLE starts on the next edge. The minimum CS-high time between frames is therefore GAP_CYC+1 cycles.
- CLK_DIV=1 is a legal boundary: SPI_Clk toggles every cycle (clk/2).
- cmd_data is captured at the handshake edge. Changes on cmd_data afterwards have no effect.

Optional Feature:
- ASKA_SPI_CFG_FIFO_EN defined:
  - A FIFO_DEPTH-entry queue sits in front of the FSM. cmd_ready = !full.
  - Push and pop in the same cycle are allowed. A push while full cannot occur.
  - A word accepted at edge N into an empty queue while IDLE lowers SPI_CS at edge N+2.
  - pending = queue non-empty.
  - Words are sent in acceptance order, back-to-back, separated by the gap only.
- ASKA_SPI_CFG_FIFO_EN undefined:
  - No queue. cmd_ready=1 only in IDLE after reset; it drops on the accepting edge and rises again on entry to IDLE.
  - A word accepted at edge N lowers SPI_CS at edge N+1.
  - pending is tied to 0.

Test Plan:
- Reset, then send 16'hA5C3 with CLK_DIV=4: SPI_CS low for 132 cycles; 16 SPI_Clk rising edges; MOSI sampled at those edges reads 1010_0101_1100_0011; exactly one frame_done pulse.
- Word 16'hFFFF with CLK_DIV=1: SPI_Clk period is 2 cycles; CS low for 33 cycles; MOSI=1 at every rising edge; SPI_Clk=0 while CS is high.
- Two words back-to-back, both variants: CS-high interval between the frames is ≥ GAP_CYC+1 = 9 cycles; second frame carries the second word; cmd_ready stays low while busy in the non-FIFO build.
- FIFO build: push 5 words without waiting: cmd_ready drops after 4 accepted; all words emerge in order; pending falls after the last frame starts.
- Assert reset_l low at bit 7 of a frame: SPI_CS=1 and SPI_Clk=0 at the next edge; no frame_done; queue emptied (pending=0); a new word afterwards transmits correctly.
- Hold cmd_valid=1 while cmd_ready=0 and change cmd_data mid-frame: the in-flight frame is unaffected; the word present at the eventual handshake edge is the one sent next.

Source files
------------

// File: rtl/aska_spi_cfg_master.sv
// aska_spi_cfg_master
//   SPI Mode 0 master that writes configuration words into aska_dig.
//   Each accepted word is shifted out MSB-first inside one SPI_CS-low frame.
//   SPI_CS then stays high for at least GAP_CYC+1 cycles before the next frame.
//
// Build option:
//   ASKA_SPI_CFG_FIFO_EN - adds a FIFO_DEPTH-entry command queue in front of
//                          the FSM. Without it, a single word is held and
//                          cmd_ready is only high while the FSM is idle.
//
// Ports:
//   clk, reset_l              system clock, synchronous active-low reset
//   cmd_valid/cmd_ready       requester handshake; cmd_data is captured on the
//   cmd_data                  edge where both are high
//   SPI_CS, SPI_Clk, SPI_MOSI SPI lines to aska_dig (CS active low, SCK idles low)
//   busy                      frame in progress, including the post-frame gap
//   frame_done                one-cycle pulse as SPI_CS rises after a frame
//   pending                   an accepted word is still waiting to start
//
// state | meaning
// IDLE  | SPI_CS high, waiting for a word
// LOW   | SPI_Clk low half-period, MOSI holds the current bit
// HIGH  | SPI_Clk high half-period, slave samples MOSI on entry
// HOLD  | SPI_CS still low for one half-period after the last bit
// GAP   | SPI_CS high for GAP_CYC cycles before returning to IDLE

module aska_spi_cfg_master #(
    parameter int FRAME_W    = 16,
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYC    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset_l,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [FRAME_W-1:0] cmd_data,
    output logic               SPI_CS,
    output logic               SPI_Clk,
    output logic               SPI_MOSI,
    output logic               busy,
    output logic               frame_done,
    output logic               pending
);

    if (FRAME_W < 2 || FRAME_W > 32) begin : g_bad_frame_w
        $error("FRAME_W must be in 2..32");
    end
    if (CLK_DIV < 1 || GAP_CYC < 1) begin : g_bad_timing
        $error("CLK_DIV and GAP_CYC must be at least 1");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end

    localparam int CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(FRAME_W);

    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYC - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);

    typedef enum logic [2:0] {IDLE, LOW, HIGH, HOLD, GAP} state_t;

    state_t             state;
    logic [CNT_W-1:0]   div_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [FRAME_W-1:0] shreg;

    logic               push;
    logic               start;
    logic               word_avail;
    logic [FRAME_W-1:0] word_data;

    assign push  = cmd_valid && cmd_ready;
    assign start = (state == IDLE) && word_avail;

`ifdef ASKA_SPI_CFG_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic [FRAME_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     fifo_cnt;
    logic [PTR_W:0]     fifo_cnt_nxt;
    logic               avail_q;

    // avail_q lags the occupancy by one cycle, so a word pushed into an empty
    // queue reaches the FSM one edge later than it would without the queue.
    assign word_avail = avail_q && (fifo_cnt != '0);
    assign word_data  = fifo_mem[rd_ptr];

    always_comb begin
        fifo_cnt_nxt = fifo_cnt;
        if (push && !start) begin
            fifo_cnt_nxt = fifo_cnt + 1'b1;
        end else if (!push && start) begin
            fifo_cnt_nxt = fifo_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= cmd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            avail_q   <= 1'b0;
            cmd_ready <= 1'b0;
            pending   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (start) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_cnt  <= fifo_cnt_nxt;
            avail_q   <= (fifo_cnt != '0);
            cmd_ready <= (fifo_cnt_nxt != FULL_CNT);
            pending   <= (fifo_cnt_nxt != '0);
        end
    end
`else
    logic               hold_v;
    logic [FRAME_W-1:0] hold_word;

    assign word_avail = hold_v;
    assign word_data  = hold_word;
    assign pending    = 1'b0;

    always_ff @(posedge clk) begin
        if (push) begin
            hold_word <= cmd_data;
        end
    end

    // cmd_ready is high only while idle with nothing held; it re-opens on the
    // edge that returns the FSM from GAP to IDLE.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            hold_v    <= 1'b0;
            cmd_ready <= 1'b0;
        end else begin
            if (push) begin
                hold_v <= 1'b1;
            end else if (start) begin
                hold_v <= 1'b0;
            end
            cmd_ready <= !push && !hold_v &&
                         ((state == IDLE) || (state == GAP && div_cnt == '0));
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            SPI_CS     <= 1'b1;
            SPI_Clk    <= 1'b0;
            SPI_MOSI   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (word_avail) begin
                        shreg    <= word_data;
                        SPI_CS   <= 1'b0;
                        SPI_MOSI <= word_data[FRAME_W-1];
                        busy     <= 1'b1;
                        bit_cnt  <= '0;
                        div_cnt  <= DIV_LOAD;
                        state    <= LOW;
                    end
                end
                LOW: begin
                    if (div_cnt == '0) begin
                        SPI_Clk <= 1'b1;
                        div_cnt <= DIV_LOAD;
                        state   <= HIGH;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                HIGH: begin
                    if (div_cnt == '0) begin
                        SPI_Clk <= 1'b0;
                        div_cnt <= DIV_LOAD;
                        if (bit_cnt == LAST_BIT) begin
                            state <= HOLD;
                        end else begin
                            // next bit goes out together with the falling SCK
                            bit_cnt  <= bit_cnt + 1'b1;
                            shreg    <= {shreg[FRAME_W-2:0], 1'b0};
                            SPI_MOSI <= shreg[FRAME_W-2];
                            state    <= LOW;
                        end
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (div_cnt == '0) begin
                        SPI_CS     <= 1'b1;
                        SPI_MOSI   <= 1'b0;
                        frame_done <= 1'b1;
                        div_cnt    <= GAP_LOAD;
                        state      <= GAP;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (div_cnt == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aska_spi_cfg_master.sv
// Bench for aska_spi_cfg_master.
//   dut0 runs at CLK_DIV=4, dut1 at CLK_DIV=1. Words are pushed to a per-DUT
//   expected queue at the handshake edge; a bus monitor rebuilds each frame
//   from MOSI at SPI_Clk rising edges and compares it with the queue head.

module tb_aska_spi_cfg_master;

    localparam int GAP = 8;
`ifdef ASKA_SPI_CFG_FIFO_EN
    localparam int LAT       = 2;
    localparam int RDY_AFTER = 1;
`else
    localparam int LAT       = 1;
    localparam int RDY_AFTER = 0;
`endif

    logic        clk;
    logic        reset_l;
    logic        valid0, ready0, cs0, sck0, mosi0, busy0, fd0, pend0;
    logic        valid1, ready1, cs1, sck1, mosi1, busy1, fd1, pend1;
    logic [15:0] data0, data1;

    aska_spi_cfg_master #(.FRAME_W(16), .CLK_DIV(4), .GAP_CYC(GAP), .FIFO_DEPTH(4)) dut0 (
        .clk(clk), .reset_l(reset_l), .cmd_valid(valid0), .cmd_ready(ready0),
        .cmd_data(data0), .SPI_CS(cs0), .SPI_Clk(sck0), .SPI_MOSI(mosi0),
        .busy(busy0), .frame_done(fd0), .pending(pend0));

    aska_spi_cfg_master #(.FRAME_W(16), .CLK_DIV(1), .GAP_CYC(GAP), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .reset_l(reset_l), .cmd_valid(valid1), .cmd_ready(ready1),
        .cmd_data(data1), .SPI_CS(cs1), .SPI_Clk(sck1), .SPI_MOSI(mosi1),
        .busy(busy1), .frame_done(fd1), .pending(pend1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    logic [15:0] q0[$];
    logic [15:0] q1[$];

    // monitor state, indexed by DUT
    bit          in_frame[2];
    bit          have_prev[2];
    logic        prev_sck[2];
    logic        prev_mosi[2];
    logic [31:0] word_sh[2];
    int          nb[2];
    int          cs_len[2];
    int          stab[2];
    int          high_len[2];
    int          started[2];
    int          done_cnt[2];
    int          fd_cyc[2];
    int          start_cyc[2];
    int          hs_cyc[2];

    task automatic mon(input int i, input logic cs, input logic sck, input logic mosi,
                       input logic fd, input logic busy, input logic rdy, input logic pend);
        int          d;
        logic [15:0] e;
        d = (i == 0) ? 4 : 1;
        if (!reset_l) begin
            in_frame[i]  = 1'b0;
            have_prev[i] = 1'b0;
            prev_sck[i]  = 1'b0;
            prev_mosi[i] = 1'b0;
        end else begin
            if (fd) fd_cyc[i]++;
`ifndef ASKA_SPI_CFG_FIFO_EN
            check_val("pending_tied", pend, 0);
            if (busy) check_val("ready_while_busy", rdy, 0);
`endif
            if (cs) begin
                check_val("sck_idle", sck, 0);
                check_val("mosi_idle", mosi, 0);
                if (in_frame[i]) begin
                    in_frame[i] = 1'b0;
                    done_cnt[i]++;
                    check_val("frame_done_at_cs_rise", fd, 1);
                    check_val("nbits", nb[i], 16);
                    check_val("cs_low_len", cs_len[i], 33 * d);
                    if (i == 0 && q0.size() > 0) begin
                        e = q0.pop_front();
                        check_val("word0", word_sh[i][15:0], e);
                    end else if (i == 1 && q1.size() > 0) begin
                        e = q1.pop_front();
                        check_val("word1", word_sh[i][15:0], e);
                    end else begin
                        check_val("unexpected_frame", 1, 0);
                    end
                    have_prev[i] = 1'b1;
                    high_len[i]  = 0;
                end
                high_len[i]++;
            end else begin
                check_val("busy_in_frame", busy, 1);
                if (!in_frame[i]) begin
                    in_frame[i]  = 1'b1;
                    nb[i]        = 0;
                    cs_len[i]    = 0;
                    word_sh[i]   = '0;
                    stab[i]      = 0;
                    start_cyc[i] = cyc;
                    started[i]++;
                    if (have_prev[i]) check_val("cs_gap_min", high_len[i] >= GAP + 1, 1);
                end
                cs_len[i]++;
                if (sck) check_val("mosi_change_sck_high", mosi, prev_mosi[i]);
                if (sck && !prev_sck[i]) begin
                    check_val("mosi_setup", stab[i] >= d, 1);
                    word_sh[i] = {word_sh[i][30:0], mosi};
                    nb[i]++;
                end
                if (mosi === prev_mosi[i] && stab[i] > 0) stab[i]++;
                else stab[i] = 1;
            end
            prev_sck[i]  = sck;
            prev_mosi[i] = mosi;
        end
    endtask

    always @(negedge clk) begin
        mon(0, cs0, sck0, mosi0, fd0, busy0, ready0, pend0);
        mon(1, cs1, sck1, mosi1, fd1, busy1, ready1, pend1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Drive a word; while cmd_ready is low, cmd_data carries junk so that only
    // the value present at the handshake edge may appear on the bus.
    task automatic send(input int i, input logic [15:0] w);
        int t = 0;
        if (i == 0) valid0 = 1'b1; else valid1 = 1'b1;
        while (!((i == 0) ? ready0 : ready1) && t < 3000) begin
            if (i == 0) data0 = 16'($urandom); else data1 = 16'($urandom);
            tick();
            t++;
        end
        if (i == 0) data0 = w; else data1 = w;
        if (t >= 3000) begin
            check_val("ready_timeout", 0, 1);
        end else begin
            @(posedge clk);
            if (i == 0) q0.push_back(w); else q1.push_back(w);
            tick();
            hs_cyc[i] = cyc;
        end
        if (i == 0) begin valid0 = 1'b0; data0 = 16'($urandom); end
        else begin valid1 = 1'b0; data1 = 16'($urandom); end
    endtask

    task automatic wait_started(input int i, input int n);
        int t = 0;
        while (started[i] < n && t < 5000) begin tick(); t++; end
        if (t >= 5000) check_val("wait_started_timeout", started[i], n);
    endtask

    task automatic wait_done(input int i, input int n);
        int t = 0;
        while (done_cnt[i] < n && t < 5000) begin tick(); t++; end
        if (t >= 5000) check_val("wait_done_timeout", done_cnt[i], n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        reset_l = 1'b0;
        valid0 = 1'b0; valid1 = 1'b0;
        data0 = '0; data1 = '0;
        repeat (3) tick();

        check_val("rst_cs", cs0, 1);
        check_val("rst_sck", sck0, 0);
        check_val("rst_mosi", mosi0, 0);
        check_val("rst_busy", busy0, 0);
        check_val("rst_fd", fd0, 0);
        check_val("rst_pending", pend0, 0);
        check_val("rst_ready", ready0, 0);
        check_val("rst_cs1", cs1, 1);

        reset_l = 1'b1;
        tick();
        check_val("ready_after_rst", ready0, 1);
        check_val("ready_after_rst1", ready1, 1);

        // first frame from idle: latency and the A5C3 pattern
        send(0, 16'hA5C3);
        check_val("ready_after_accept", ready0, RDY_AFTER);
        wait_started(0, 1);
        check_val("start_latency", start_cyc[0] - hs_cyc[0], LAT);

        // CLK_DIV=1 instance, two back-to-back words
        send(1, 16'hFFFF);
        send(1, 16'h8001);

        // back-to-back on dut0; the second waits with junk on cmd_data
        send(0, 16'h1234);
        send(0, 16'hBEEF);
        wait_done(0, 3);
        wait_done(1, 2);

`ifdef ASKA_SPI_CFG_FIFO_EN
        send(0, 16'h0F0F);
        wait_started(0, 4);
        send(0, 16'h1111);
        send(0, 16'h2222);
        send(0, 16'h3333);
        send(0, 16'h4444);
        check_val("fifo_full_ready", ready0, 0);
        check_val("fifo_pending", pend0, 1);
        send(0, 16'h5555);
        wait_started(0, 8);
        check_val("pending_before_last", pend0, 1);
        wait_started(0, 9);
        check_val("pending_after_last", pend0, 0);
        wait_done(0, 9);
`endif

        // reset in the middle of a frame
        send(0, 16'hC0DE);
`ifdef ASKA_SPI_CFG_FIFO_EN
        send(0, 16'h7777);
        send(0, 16'h6666);
        check_val("pending_before_rst", pend0, 1);
`endif
        t = 0;
        while (!(in_frame[0] && nb[0] >= 7) && t < 5000) begin tick(); t++; end
        if (t >= 5000) check_val("wait_bit7_timeout", nb[0], 7);
        t = done_cnt[0];
        reset_l = 1'b0;
        tick();
        check_val("abort_cs", cs0, 1);
        check_val("abort_sck", sck0, 0);
        check_val("abort_fd", fd0, 0);
        check_val("abort_pending", pend0, 0);
        check_val("abort_busy", busy0, 0);
        q0.delete();
        tick();
        reset_l = 1'b1;
        tick();
        check_val("abort_no_done", done_cnt[0], t);
        repeat (20) tick();
        check_val("abort_stays_idle", cs0, 1);

        send(0, 16'h5A5A);
        wait_done(0, t + 1);
        repeat (12) tick();

        check_val("fd_count0", fd_cyc[0], done_cnt[0]);
        check_val("fd_count1", fd_cyc[1], done_cnt[1]);
        check_val("q0_empty", q0.size(), 0);
        check_val("q1_empty", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
